// File: rtl/dmem_pkg.sv
// ============================================================================
// Module : dmem_pkg
// Brief  : Shared access-size encodings, FSM state type and index-width helper
//          for data_memory_sync.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package dmem_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/data_memory_sync_if.sv
// ============================================================================
// Module : data_memory_sync_if
// Brief  : MEM-stage request/response bundle between datapath and data memory.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface data_memory_sync_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
);
    logic                  MemRead;
    logic                  MemWrite;
    logic [1:0]            MemSize;
    logic                  MemSigned;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] write_data;
    logic                  req_ready;
    logic [DATA_WIDTH-1:0] read_data;
    logic                  read_valid;
    logic                  misalign;

    modport master (
        output MemRead, MemWrite, MemSize, MemSigned, addr, write_data,
        input  req_ready, read_data, read_valid, misalign
    );

    modport slave (
        input  MemRead, MemWrite, MemSize, MemSigned, addr, write_data,
        output req_ready, read_data, read_valid, misalign
    );
endinterface

`default_nettype wire

// File: rtl/dmem_lane_align.sv
// ============================================================================
// Module : dmem_lane_align
// Brief  : Combinational byte-lane steering: store enables/data and load
//          extraction/extension. Alignment trap under DMEM_MISALIGN_TRAP_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module dmem_lane_align
    import dmem_pkg::*;
(
    input  wire logic [1:0]  i_size,
    input  wire logic [1:0]  i_offset,
    input  wire logic        i_signed,
    input  wire logic [31:0] i_store_data,
    input  wire logic [31:0] i_mem_word,
    output logic      [3:0]  o_byte_en,
    output logic      [31:0] o_store_data,
    output logic      [31:0] o_load_data,
    output logic             o_misalign
);

    logic [1:0]  w_off;
    logic [31:0] w_shifted;
    logic        w_mis;

    always_comb begin
        w_mis = 1'b0;
`ifdef DMEM_MISALIGN_TRAP_EN
        if (i_size == SIZE_HALF) begin
            w_mis = i_offset[0];
        end else if (i_size != SIZE_BYTE) begin
            w_mis = (i_offset != 2'b00);
        end
`endif
        // Without the trap, low offset bits are simply dropped to align.
        case (i_size)
            SIZE_BYTE: w_off = i_offset;
            SIZE_HALF: w_off = {i_offset[1], 1'b0};
            default:   w_off = 2'b00;
        endcase

        w_shifted = i_mem_word >> {w_off, 3'b000};

        case (i_size)
            SIZE_BYTE: begin
                o_byte_en    = 4'b0001 << w_off;
                o_store_data = {4{i_store_data[7:0]}};
                o_load_data  = {{24{i_signed & w_shifted[7]}}, w_shifted[7:0]};
            end
            SIZE_HALF: begin
                o_byte_en    = 4'b0011 << w_off;
                o_store_data = {2{i_store_data[15:0]}};
                o_load_data  = {{16{i_signed & w_shifted[15]}}, w_shifted[15:0]};
            end
            default: begin
                o_byte_en    = 4'b1111;
                o_store_data = i_store_data;
                o_load_data  = i_mem_word;
            end
        endcase

        if (w_mis) begin
            o_byte_en   = 4'b0000;
            o_load_data = 32'h0000_0000;
        end
        o_misalign = w_mis;
    end

endmodule

`default_nettype wire

// File: rtl/data_memory_sync.sv
// ============================================================================
// Module : data_memory_sync
// Brief  : Clocked byte-addressable data memory, single-cycle writes and
//          READ_LATENCY-cycle reads. Optional macro: DMEM_MISALIGN_TRAP_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module data_memory_sync
    import dmem_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 32,
    parameter int DEPTH_WORDS  = 256,
    parameter int READ_LATENCY = 1
)(
    input  wire logic         clk,
    input  wire logic         reset,
    data_memory_sync_if.slave bus
);

    localparam int         c_IDX_W  = clog2(DEPTH_WORDS);
    localparam logic [1:0] c_LAT_M1 = 2'(READ_LATENCY - 1);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH_WORDS];

    state_t                r_state;
    logic [1:0]            r_cnt;
    logic                  r_req_ready;
    logic [DATA_WIDTH-1:0] r_read_data;
    logic [DATA_WIDTH-1:0] r_pend_data;
    logic                  r_read_valid;
    logic                  r_misalign;

    logic [c_IDX_W-1:0]    w_idx;
    logic [3:0]            w_byte_en;
    logic [DATA_WIDTH-1:0] w_store_data;
    logic [DATA_WIDTH-1:0] w_load_data;
    logic                  w_mis;
    logic                  w_wr_go;
    logic                  w_rd_go;
    logic                  w_unused_addr;

    assign w_idx         = bus.addr[c_IDX_W+1:2];
    assign w_unused_addr = &{1'b0, bus.addr[ADDR_WIDTH-1:c_IDX_W+2]};

    // Write wins when both strobes are high; the read is dropped.
    assign w_wr_go = (r_state == IDLE) && bus.MemWrite && !reset;
    assign w_rd_go = (r_state == IDLE) && bus.MemRead && !bus.MemWrite;

    dmem_lane_align u_align (
        .i_size       (bus.MemSize),
        .i_offset     (bus.addr[1:0]),
        .i_signed     (bus.MemSigned),
        .i_store_data (bus.write_data),
        .i_mem_word   (r_mem[w_idx]),
        .o_byte_en    (w_byte_en),
        .o_store_data (w_store_data),
        .o_load_data  (w_load_data),
        .o_misalign   (w_mis)
    );

    always_ff @(posedge clk) begin
        if (w_wr_go) begin
            for (int i = 0; i < 4; i++) begin
                if (w_byte_en[i]) begin
                    r_mem[w_idx][8*i +: 8] <= w_store_data[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= IDLE;
            r_cnt        <= 2'd0;
            r_req_ready  <= 1'b1;
            r_read_data  <= '0;
            r_pend_data  <= '0;
            r_read_valid <= 1'b0;
            r_misalign   <= 1'b0;
        end else begin
            r_read_valid <= 1'b0;
            r_misalign   <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.MemRead || bus.MemWrite) begin
                        r_misalign <= w_mis;
                    end
                    if (w_rd_go) begin
                        r_state     <= WAIT;
                        r_req_ready <= 1'b0;
                        r_cnt       <= c_LAT_M1;
                        // read_valid lands in the last of the READ_LATENCY busy cycles.
                        if (READ_LATENCY == 1) begin
                            r_read_valid <= 1'b1;
                            r_read_data  <= w_load_data;
                        end else begin
                            r_pend_data  <= w_load_data;
                        end
                    end
                end
                WAIT: begin
                    if (r_cnt == 2'd0) begin
                        r_state     <= IDLE;
                        r_req_ready <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - 2'd1;
                        if (r_cnt == 2'd1) begin
                            r_read_valid <= 1'b1;
                            r_read_data  <= r_pend_data;
                        end
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_req_ready <= 1'b1;
                end
            endcase
        end
    end

    assign bus.req_ready  = r_req_ready;
    assign bus.read_data  = r_read_data;
    assign bus.read_valid = r_read_valid;
    assign bus.misalign   = r_misalign;

endmodule

`default_nettype wire

// File: tb/tb_data_memory_sync.sv
// ============================================================================
// Module : tb_data_memory_sync
// Brief  : Scoreboard bench driving READ_LATENCY=1 and =3 instances in lockstep
//          against a byte-array reference model.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_data_memory_sync;
    import dmem_pkg::*;

    localparam int DEPTH = 256;
    localparam int MEMB  = DEPTH * 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        tb_rd = 1'b0, tb_wr = 1'b0, tb_sg = 1'b0;
    logic [1:0]  tb_sz = 2'b00;
    logic [31:0] tb_a = '0, tb_wd = '0;

    always #5 clk = ~clk;

    data_memory_sync_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) bus1 ();
    data_memory_sync_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) bus3 ();

    assign bus1.MemRead = tb_rd;  assign bus3.MemRead = tb_rd;
    assign bus1.MemWrite = tb_wr; assign bus3.MemWrite = tb_wr;
    assign bus1.MemSize = tb_sz;  assign bus3.MemSize = tb_sz;
    assign bus1.MemSigned = tb_sg; assign bus3.MemSigned = tb_sg;
    assign bus1.addr = tb_a;      assign bus3.addr = tb_a;
    assign bus1.write_data = tb_wd; assign bus3.write_data = tb_wd;

    data_memory_sync #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .DEPTH_WORDS(DEPTH), .READ_LATENCY(1))
        dut1 (.clk(clk), .reset(reset), .bus(bus1));
    data_memory_sync #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .DEPTH_WORDS(DEPTH), .READ_LATENCY(3))
        dut3 (.clk(clk), .reset(reset), .bus(bus3));

    typedef struct packed {
        logic [31:0] data;
        int          due;
    } exp_t;

    exp_t       q0[$], q1[$];
    int         cyc = 0;
    int         busy_until[2] = '{0, 0};
    int         mis_due = -10;
    bit         started = 1'b0;
    int         checks = 0, errors = 0;
    logic [7:0] mem [MEMB];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int nbytes(logic [1:0] sz);
        case (sz)
            SIZE_BYTE: return 1;
            SIZE_HALF: return 2;
            default:   return 4;
        endcase
    endfunction

    function automatic bit model_mis(logic [1:0] sz, logic [31:0] a);
`ifdef DMEM_MISALIGN_TRAP_EN
        return (int'(a[1:0]) % nbytes(sz)) != 0;
`else
        return 1'b0;
`endif
    endfunction

    function automatic int base_of(logic [1:0] sz, logic [31:0] a);
        return (int'(a) & (MEMB - 1)) & ~(nbytes(sz) - 1);
    endfunction

    function automatic logic [31:0] model_read(logic [1:0] sz, bit sg, logic [31:0] a);
        logic [31:0] v;
        int b, n;
        n = nbytes(sz);
        b = base_of(sz, a);
        v = '0;
        for (int k = 0; k < n; k++) v[8*k +: 8] = mem[b + k];
        if (n == 1) v = {{24{sg & v[7]}}, v[7:0]};
        else if (n == 2) v = {{16{sg & v[15]}}, v[15:0]};
        return v;
    endfunction

    task automatic mon(int d, logic rv, logic [31:0] rdat, logic rdy, logic mis);
        exp_t e;
        bit   have;
        have = (d == 0) ? (q0.size() > 0) : (q1.size() > 0);
        if (have) e = (d == 0) ? q0[0] : q1[0];
        check($sformatf("req_ready_L%0d", d * 2 + 1), {31'b0, rdy}, {31'b0, cyc >= busy_until[d]});
        check($sformatf("misalign_L%0d", d * 2 + 1), {31'b0, mis}, {31'b0, cyc == mis_due});
        if (rv) begin
            if (!have) begin
                check($sformatf("spurious_valid_L%0d", d * 2 + 1), 32'd1, 32'd0);
            end else begin
                check($sformatf("read_data_L%0d", d * 2 + 1), rdat, e.data);
                check($sformatf("valid_cycle_L%0d", d * 2 + 1), 32'(cyc), 32'(e.due));
                if (d == 0) void'(q0.pop_front()); else void'(q1.pop_front());
            end
        end else if (have && e.due < cyc) begin
            check($sformatf("missing_valid_L%0d", d * 2 + 1), 32'd0, 32'd1);
            if (d == 0) void'(q0.pop_front()); else void'(q1.pop_front());
        end
    endtask

    always @(negedge clk) begin
        if (started) begin
            mon(0, bus1.read_valid, bus1.read_data, bus1.req_ready, bus1.misalign);
            mon(1, bus3.read_valid, bus3.read_data, bus3.req_ready, bus3.misalign);
        end
    end

    task automatic wait_ready();
        int t;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!(bus1.req_ready && bus3.req_ready) && t < 50);
        if (!(bus1.req_ready && bus3.req_ready)) check("ready_timeout", 32'd0, 32'd1);
    endtask

    // Model side effects of a request accepted at the edge just taken.
    task automatic model_accept(bit rd, bit wr, logic [1:0] sz, bit sg, logic [31:0] a,
                                logic [31:0] wd, int e_cyc);
        bit          mis;
        logic [31:0] v;
        int          b;
        mis = model_mis(sz, a);
        if (mis && (rd || wr)) mis_due = e_cyc;
        if (wr) begin
            b = base_of(sz, a);
            if (!mis) for (int k = 0; k < nbytes(sz); k++) mem[b + k] = wd[8*k +: 8];
        end else if (rd) begin
            v = mis ? 32'h0 : model_read(sz, sg, a);
            q0.push_back('{data: v, due: e_cyc});
            q1.push_back('{data: v, due: e_cyc + 2});
            busy_until[0] = e_cyc + 1;
            busy_until[1] = e_cyc + 3;
        end
    endtask

    task automatic issue(bit rd, bit wr, logic [1:0] sz, bit sg, logic [31:0] a,
                         logic [31:0] wd, bit nowait);
        if (!nowait) wait_ready();
        tb_rd = rd; tb_wr = wr; tb_sz = sz; tb_sg = sg; tb_a = a; tb_wd = wd;
        @(posedge clk);
        #1;
        tb_rd = 1'b0; tb_wr = 1'b0;
        model_accept(rd, wr, sz, sg, a, wd, cyc);
    endtask

    initial begin
        int t;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        started = 1'b1;
        check("rst_rdata_L1", bus1.read_data, 32'h0);
        check("rst_rdata_L3", bus3.read_data, 32'h0);
        check("rst_valid_L1", {31'b0, bus1.read_valid}, 32'h0);
        check("rst_valid_L3", {31'b0, bus3.read_valid}, 32'h0);
        check("rst_ready_L1", {31'b0, bus1.req_ready}, 32'h1);
        check("rst_ready_L3", {31'b0, bus3.req_ready}, 32'h1);

        // Back-to-back word writes fill every location.
        for (int w = 0; w < DEPTH; w++) issue(0, 1, SIZE_WORD, 0, 32'(w * 4), $urandom, 1);

        issue(0, 1, SIZE_WORD, 0, 32'h0, 32'h0000_0003, 0);
        issue(1, 0, SIZE_WORD, 0, 32'h0, 32'h0, 0);
        issue(0, 1, SIZE_WORD, 0, 32'h4, 32'h1122_3344, 0);
        issue(0, 1, SIZE_BYTE, 0, 32'h6, 32'h0000_00AB, 0);
        issue(1, 0, SIZE_WORD, 0, 32'h4, 32'h0, 0);
        issue(1, 0, SIZE_BYTE, 1, 32'h6, 32'h0, 0);
        issue(1, 0, SIZE_BYTE, 0, 32'h6, 32'h0, 0);
        issue(0, 1, SIZE_HALF, 0, 32'h8, 32'h0000_8001, 0);
        issue(1, 0, SIZE_HALF, 1, 32'h8, 32'h0, 0);
        issue(1, 0, SIZE_HALF, 0, 32'h8, 32'h0, 0);
        issue(1, 1, SIZE_WORD, 0, 32'hC, 32'hCAFE_F00D, 0);
        issue(0, 1, SIZE_WORD, 0, 32'h14, 32'h5555_AAAA, 0);
        issue(1, 0, SIZE_WORD, 0, 32'h14, 32'h0, 1);
        issue(0, 1, SIZE_WORD, 0, 32'h11, 32'hDEAD_BEEF, 0);
        issue(1, 0, SIZE_WORD, 0, 32'h10, 32'h0, 0);
        issue(1, 0, SIZE_HALF, 1, 32'h13, 32'h0, 0);
        issue(1, 0, SIZE_WORD, 0, 32'h0000_1404, 32'h0, 0);

        // Write held during the L3 wait window must only land once ready returns.
        issue(1, 0, SIZE_WORD, 0, 32'h0, 32'h0, 0);
        tb_wr = 1'b1; tb_sz = SIZE_WORD; tb_a = 32'h20; tb_wd = 32'h0BAD_F00D;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!bus3.req_ready && t < 10);
        if (!bus3.req_ready) check("hold_ready_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        tb_wr = 1'b0;
        model_accept(0, 1, SIZE_WORD, 0, 32'h20, 32'h0BAD_F00D, cyc);
        issue(1, 0, SIZE_WORD, 0, 32'h20, 32'h0, 0);

        // Reset in the second wait cycle of the L3 read discards it.
        issue(1, 0, SIZE_WORD, 0, 32'h4, 32'h0, 0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        q0.delete();
        q1.delete();
        busy_until[0] = 0;
        busy_until[1] = 0;
        check("rst_wait_rdata_L3", bus3.read_data, 32'h0);
        check("rst_wait_ready_L3", {31'b0, bus3.req_ready}, 32'h1);
        issue(1, 0, SIZE_HALF, 0, 32'h6, 32'h0, 0);

        for (int i = 0; i < 300; i++) begin
            int op;
            op = int'($urandom_range(0, 2));
            issue(op != 1, op != 0, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                  $urandom, $urandom, 0);
        end

        repeat (6) @(negedge clk);
        check("drain", 32'(q0.size() + q1.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
